vadd_mc_arb: RTL and testbench



---
 rtl/vadd_mc_arb.sv | 208 ++++++++++++++++++++
 tb/tb_vadd_mc_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_mc_arb.sv
// Two-requester round-robin arbiter merging vadd unit load/store traffic onto one
// memory-controller port, with load tagging and per-unit response steering.
module vadd_mc_arb #(
    parameter int QDEPTH = 8,
    parameter int QAFULL = QDEPTH - 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        u0_req_ld,
    input  logic        u0_req_st,
    input  logic [47:0] u0_req_vadr,
    input  logic [63:0] u0_req_wrd_rdctl,
    output logic        u0_rd_rq_stall,
    output logic        u0_wr_rq_stall,
    input  logic        u1_req_ld,
    input  logic        u1_req_st,
    input  logic [47:0] u1_req_vadr,
    input  logic [63:0] u1_req_wrd_rdctl,
    output logic        u1_rd_rq_stall,
    output logic        u1_wr_rq_stall,

    output logic        u0_rsp_push,
    output logic [31:0] u0_rsp_rdctl,
    output logic [63:0] u0_rsp_data,
    input  logic        u0_rsp_stall,
    output logic        u1_rsp_push,
    output logic [31:0] u1_rsp_rdctl,
    output logic [63:0] u1_rsp_data,
    input  logic        u1_rsp_stall,

    output logic        mc_req_ld,
    output logic        mc_req_st,
    output logic [47:0] mc_req_vadr,
    output logic [63:0] mc_req_wrd_rdctl,
    input  logic        mc_rd_rq_stall,
    input  logic        mc_wr_rq_stall,

    input  logic        mc_rsp_push,
    input  logic [31:0] mc_rsp_rdctl,
    input  logic [63:0] mc_rsp_data,
    output logic        mc_rsp_stall,

    output logic        arb_idle,
    output logic        q_ovrflw,
    output logic        rsp_unexp
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 + 48 + 64;
    localparam logic [CW-1:0] FULL_C  = CW'(QDEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(QAFULL);

    function automatic logic [63:0] tag_rdctl(input logic [63:0] v, input logic id);
        logic [63:0] t;
        t     = v;
        t[30] = id;
        return t;
    endfunction

    function automatic logic [31:0] untag_rdctl(input logic [31:0] v);
        logic [31:0] t;
        t     = v;
        t[30] = 1'b0;
        return t;
    endfunction

    logic [1:0]          in_ld, in_st;
    logic [47:0]         in_vadr [2];
    logic [63:0]         in_wrd  [2];
    logic [1:0][CW-1:0]  qcnt_v;
    logic [1:0]          q_empty, head_ld, head_st, elig, gnt, push_ok, drop;
    logic [47:0]         head_vadr [2];
    logic [63:0]         head_wrd  [2];
    logic [1:0]          oc_zero, unexp_hit, rsp_push_v;
    logic                gnt_id;
    logic                rr_next;
    logic                r_mc_rd_rq_stall, r_mc_wr_rq_stall;
    logic                r_mc_rsp_push;
    logic [31:0]         r_mc_rsp_rdctl;
    logic [63:0]         r_mc_rsp_data;

    assign in_ld      = {u1_req_ld, u0_req_ld};
    assign in_st      = {u1_req_st, u0_req_st};
    assign in_vadr[0] = u0_req_vadr;
    assign in_vadr[1] = u1_req_vadr;
    assign in_wrd[0]  = u0_req_wrd_rdctl;
    assign in_wrd[1]  = u1_req_wrd_rdctl;
    assign rsp_push_v = {r_mc_rsp_push & r_mc_rsp_rdctl[30], r_mc_rsp_push & ~r_mc_rsp_rdctl[30]};

    for (genvar u = 0; u < 2; u++) begin : g_unit
        logic [EW-1:0] mem [QDEPTH];
        logic [AW-1:0] wptr, rptr;
        logic [CW-1:0] cnt;
        logic [15:0]   oc;
        logic          req, inc, dec;

        // A pop frees the head slot this edge, so a push at full is still accepted.
        assign req        = in_ld[u] | in_st[u];
        assign push_ok[u] = req & ((cnt != FULL_C) | gnt[u]);
        assign drop[u]    = (req & ~push_ok[u]) | (in_ld[u] & in_st[u]);
        assign q_empty[u] = (cnt == '0);
        assign qcnt_v[u]  = cnt;
        assign {head_ld[u], head_st[u], head_vadr[u], head_wrd[u]} = mem[rptr];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push_ok[u]) wptr <= wptr + 1'b1;
                if (gnt[u])     rptr <= rptr + 1'b1;
                if (push_ok[u] & ~gnt[u])      cnt <= cnt + 1'b1;
                else if (gnt[u] & ~push_ok[u]) cnt <= cnt - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push_ok[u])
                mem[wptr] <= {in_ld[u] & ~in_st[u], in_st[u], in_vadr[u], in_wrd[u]};
        end

        assign inc          = gnt[u] & head_ld[u];
        assign dec          = rsp_push_v[u];
        assign oc_zero[u]   = (oc == '0);
        assign unexp_hit[u] = dec & ~inc & oc_zero[u];

        always_ff @(posedge clk) begin
            if (!reset_n)
                oc <= '0;
            else if (inc & ~dec & (oc != 16'hFFFF))
                oc <= oc + 16'd1;
            else if (dec & ~inc & ~oc_zero[u])
                oc <= oc - 16'd1;
        end
    end

    // Stalls are held low while reset is asserted, whatever the queue held.
    assign u0_rd_rq_stall = reset_n & (qcnt_v[0] >= AFULL_C);
    assign u0_wr_rq_stall = u0_rd_rq_stall;
    assign u1_rd_rq_stall = reset_n & (qcnt_v[1] >= AFULL_C);
    assign u1_wr_rq_stall = u1_rd_rq_stall;

    always_comb begin
        elig = '0;
        gnt  = '0;
        for (int u = 0; u < 2; u++)
            elig[u] = ~q_empty[u] & (head_st[u] ? ~r_mc_wr_rq_stall : ~r_mc_rd_rq_stall);
        if (&elig)
            gnt[rr_next] = 1'b1;
        else
            gnt = elig;
    end

    assign gnt_id = gnt[1];

    // Grant stage: pop and load the MC request registers on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mc_req_ld        <= 1'b0;
            mc_req_st        <= 1'b0;
            mc_req_vadr      <= '0;
            mc_req_wrd_rdctl <= '0;
            rr_next          <= 1'b0;
            r_mc_rd_rq_stall <= 1'b0;
            r_mc_wr_rq_stall <= 1'b0;
            q_ovrflw         <= 1'b0;
            rsp_unexp        <= 1'b0;
        end else begin
            r_mc_rd_rq_stall <= mc_rd_rq_stall;
            r_mc_wr_rq_stall <= mc_wr_rq_stall;
            mc_req_ld        <= |(gnt & head_ld);
            mc_req_st        <= |(gnt & head_st);
            if (|gnt) begin
                rr_next          <= ~gnt_id;
                mc_req_vadr      <= head_vadr[gnt_id];
                mc_req_wrd_rdctl <= head_st[gnt_id] ? head_wrd[gnt_id]
                                                    : tag_rdctl(head_wrd[gnt_id], gnt_id);
            end
            q_ovrflw  <= q_ovrflw | (|drop);
            rsp_unexp <= rsp_unexp | (|unexp_hit);
        end
    end

    // Response stage: one register between the MC and the units.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mc_rsp_push  <= 1'b0;
            r_mc_rsp_rdctl <= '0;
            r_mc_rsp_data  <= '0;
        end else begin
            r_mc_rsp_push  <= mc_rsp_push;
            r_mc_rsp_rdctl <= mc_rsp_rdctl;
            r_mc_rsp_data  <= mc_rsp_data;
        end
    end

    assign u0_rsp_push  = rsp_push_v[0];
    assign u1_rsp_push  = rsp_push_v[1];
    assign u0_rsp_rdctl = untag_rdctl(r_mc_rsp_rdctl);
    assign u1_rsp_rdctl = untag_rdctl(r_mc_rsp_rdctl);
    assign u0_rsp_data  = r_mc_rsp_data;
    assign u1_rsp_data  = r_mc_rsp_data;
    assign mc_rsp_stall = u0_rsp_stall | u1_rsp_stall;

    assign arb_idle = (&q_empty) & (&oc_zero) & ~mc_req_ld & ~mc_req_st;
endmodule

// File: tb/tb_vadd_mc_arb.sv
// Directed bench for vadd_mc_arb: reset, single load, fairness, back-pressure,
// mixed stalls, unexpected responses and mid-stream reset.
module tb_vadd_mc_arb;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        u0_req_ld, u0_req_st, u1_req_ld, u1_req_st;
    logic [47:0] u0_req_vadr, u1_req_vadr;
    logic [63:0] u0_req_wrd_rdctl, u1_req_wrd_rdctl;
    logic        u0_rd_rq_stall, u0_wr_rq_stall, u1_rd_rq_stall, u1_wr_rq_stall;
    logic        u0_rsp_push, u1_rsp_push;
    logic [31:0] u0_rsp_rdctl, u1_rsp_rdctl;
    logic [63:0] u0_rsp_data, u1_rsp_data;
    logic        u0_rsp_stall, u1_rsp_stall;
    logic        mc_req_ld, mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd_rdctl;
    logic        mc_rd_rq_stall, mc_wr_rq_stall;
    logic        mc_rsp_push;
    logic [31:0] mc_rsp_rdctl;
    logic [63:0] mc_rsp_data;
    logic        mc_rsp_stall;
    logic        arb_idle, q_ovrflw, rsp_unexp;

    int total = 0;
    int bad   = 0;

    vadd_mc_arb dut (
        .clk(clk), .reset_n(reset_n),
        .u0_req_ld(u0_req_ld), .u0_req_st(u0_req_st), .u0_req_vadr(u0_req_vadr),
        .u0_req_wrd_rdctl(u0_req_wrd_rdctl), .u0_rd_rq_stall(u0_rd_rq_stall),
        .u0_wr_rq_stall(u0_wr_rq_stall),
        .u1_req_ld(u1_req_ld), .u1_req_st(u1_req_st), .u1_req_vadr(u1_req_vadr),
        .u1_req_wrd_rdctl(u1_req_wrd_rdctl), .u1_rd_rq_stall(u1_rd_rq_stall),
        .u1_wr_rq_stall(u1_wr_rq_stall),
        .u0_rsp_push(u0_rsp_push), .u0_rsp_rdctl(u0_rsp_rdctl), .u0_rsp_data(u0_rsp_data),
        .u0_rsp_stall(u0_rsp_stall),
        .u1_rsp_push(u1_rsp_push), .u1_rsp_rdctl(u1_rsp_rdctl), .u1_rsp_data(u1_rsp_data),
        .u1_rsp_stall(u1_rsp_stall),
        .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr),
        .mc_req_wrd_rdctl(mc_req_wrd_rdctl), .mc_rd_rq_stall(mc_rd_rq_stall),
        .mc_wr_rq_stall(mc_wr_rq_stall),
        .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data),
        .mc_rsp_stall(mc_rsp_stall),
        .arb_idle(arb_idle), .q_ovrflw(q_ovrflw), .rsp_unexp(rsp_unexp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        u0_req_ld = 0; u0_req_st = 0; u0_req_vadr = '0; u0_req_wrd_rdctl = '0;
        u1_req_ld = 0; u1_req_st = 0; u1_req_vadr = '0; u1_req_wrd_rdctl = '0;
        u0_rsp_stall = 0; u1_rsp_stall = 0;
        mc_rd_rq_stall = 0; mc_wr_rq_stall = 0;
        mc_rsp_push = 0; mc_rsp_rdctl = '0; mc_rsp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    logic [63:0] q0[$], q1[$];
    logic [63:0] w0, w1, ev;
    logic        rr, p0, p1;
    int          eu;

    initial begin
        clear_inputs();
        reset_n = 0;
        tick();
        chk("rst_stall_during", u0_rd_rq_stall, 0);
        tick();
        reset_n = 1;
        chk("rst_idle", arb_idle, 1);
        chk("rst_mc_ld", mc_req_ld, 0);
        chk("rst_ovrflw", q_ovrflw, 0);
        chk("rst_unexp", rsp_unexp, 0);
        chk("rst_vadr", mc_req_vadr, 0);

        // single load from u0
        u0_req_ld = 1; u0_req_vadr = 48'h1000; u0_req_wrd_rdctl = 64'h8000_0005;
        tick();
        u0_req_ld = 0;
        chk("sl_ld_c1", mc_req_ld, 0);
        chk("sl_busy", arb_idle, 0);
        tick();
        chk("sl_ld_c2", mc_req_ld, 1);
        chk("sl_vadr", mc_req_vadr, 48'h1000);
        chk("sl_rdctl", mc_req_wrd_rdctl, 64'h8000_0005);
        tick();
        chk("sl_ld_off", mc_req_ld, 0);
        chk("sl_outst", arb_idle, 0);
        mc_rsp_push = 1; mc_rsp_rdctl = 32'h8000_0005; mc_rsp_data = 64'h1234_5678;
        tick();
        mc_rsp_push = 0;
        chk("sl_u0_push", u0_rsp_push, 1);
        chk("sl_u1_push", u1_rsp_push, 0);
        chk("sl_u0_rdctl", u0_rsp_rdctl, 32'h8000_0005);
        chk("sl_u0_data", u0_rsp_data, 64'h1234_5678);
        tick();
        chk("sl_u0_push_off", u0_rsp_push, 0);
        chk("sl_idle", arb_idle, 1);
        chk("sl_unexp", rsp_unexp, 0);

        // fairness: both units stream loads, honouring their stalls
        do_reset();
        rr = 0;
        for (int c = 0; c < 60; c++) begin
            w0 = 64'h4000_0000 | 64'(c);
            w1 = 64'h0000_0100 | 64'(c);
            p0 = (c < 20) && !u0_rd_rq_stall;
            p1 = (c < 20) && !u1_rd_rq_stall;
            u0_req_ld = p0; u0_req_vadr = {32'h0, w0[15:0]}; u0_req_wrd_rdctl = w0;
            u1_req_ld = p1; u1_req_vadr = {32'h0, w1[15:0]}; u1_req_wrd_rdctl = w1;
            tick();
            if (q0.size() != 0 && q1.size() != 0) eu = rr ? 1 : 0;
            else if (q0.size() != 0)              eu = 0;
            else if (q1.size() != 0)              eu = 1;
            else                                  eu = -1;
            chk("fair_ld", mc_req_ld, (eu >= 0) ? 64'd1 : 64'd0);
            if (eu >= 0) begin
                ev = (eu == 0) ? (q0.pop_front() & ~64'h4000_0000)
                               : (q1.pop_front() | 64'h4000_0000);
                chk("fair_rdctl", mc_req_wrd_rdctl, ev);
                chk("fair_vadr", mc_req_vadr, {32'h0, ev[15:0]});
                rr = (eu == 0);
            end
            if (p0) q0.push_back(w0);
            if (p1) q1.push_back(w1);
        end
        clear_inputs();
        chk("fair_ovrflw", q_ovrflw, 0);
        chk("fair_outst", arb_idle, 0);
        mc_rsp_push = 1; mc_rsp_rdctl = 32'h4000_0003; mc_rsp_data = 64'h55;
        tick();
        mc_rsp_push = 0;
        chk("fair_u1_push", u1_rsp_push, 1);
        chk("fair_u0_push", u0_rsp_push, 0);
        chk("fair_u1_rdctl", u1_rsp_rdctl, 32'h0000_0003);
        chk("fair_u1_data", u1_rsp_data, 64'h55);

        // back-pressure from the MC read side
        do_reset();
        mc_rd_rq_stall = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            u0_req_ld = 1; u0_req_vadr = 48'(i); u0_req_wrd_rdctl = 64'(i);
            tick();
            chk("bp_rd_stall", u0_rd_rq_stall, ((i + 1) >= 6) ? 64'd1 : 64'd0);
            chk("bp_wr_stall", u0_wr_rq_stall, ((i + 1) >= 6) ? 64'd1 : 64'd0);
            chk("bp_no_req", mc_req_ld, 0);
        end
        chk("bp_no_ovrflw", q_ovrflw, 0);
        chk("bp_u1_stall", u1_rd_rq_stall, 0);
        u0_req_vadr = 48'd8;
        tick();
        u0_req_ld = 0;
        chk("bp_ovrflw", q_ovrflw, 1);
        chk("bp_stall_full", u0_rd_rq_stall, 1);
        reset_n = 0;
        #1;
        chk("bp_stall_in_rst", u0_rd_rq_stall, 0);
        tick();
        reset_n = 1;

        // mixed stall: u0 store blocked by wr stall, u1 loads flow
        clear_inputs();
        mc_wr_rq_stall = 1;
        u0_req_st = 1; u0_req_vadr = 48'hA0; u0_req_wrd_rdctl = 64'hDEAD;
        u1_req_ld = 1; u1_req_vadr = 48'hB0; u1_req_wrd_rdctl = 64'h7;
        tick();
        u0_req_st = 0;
        u1_req_vadr = 48'hB1; u1_req_wrd_rdctl = 64'h8;
        chk("mx_none", mc_req_ld | mc_req_st, 0);
        tick();
        u1_req_ld = 0;
        chk("mx_ld1", mc_req_ld, 1);
        chk("mx_st1", mc_req_st, 0);
        chk("mx_vadr1", mc_req_vadr, 48'hB0);
        chk("mx_rdctl1", mc_req_wrd_rdctl, 64'h4000_0007);
        tick();
        chk("mx_ld2", mc_req_ld, 1);
        chk("mx_vadr2", mc_req_vadr, 48'hB1);
        tick();
        chk("mx_idle_ld", mc_req_ld, 0);
        chk("mx_idle_st", mc_req_st, 0);
        mc_wr_rq_stall = 0;
        tick();
        chk("mx_st_wait", mc_req_st, 0);
        tick();
        chk("mx_st", mc_req_st, 1);
        chk("mx_st_ld", mc_req_ld, 0);
        chk("mx_st_vadr", mc_req_vadr, 48'hA0);
        chk("mx_st_data", mc_req_wrd_rdctl, 64'hDEAD);

        // unexpected response for u1 and response stall merge
        do_reset();
        mc_rsp_push = 1; mc_rsp_rdctl = 32'h4000_0000;
        tick();
        mc_rsp_push = 0;
        chk("ux_u1_push", u1_rsp_push, 1);
        chk("ux_u1_rdctl", u1_rsp_rdctl, 0);
        tick();
        chk("ux_flag", rsp_unexp, 1);
        chk("ux_idle", arb_idle, 1);
        tick();
        chk("ux_sticky", rsp_unexp, 1);
        u1_rsp_stall = 1;
        #1;
        chk("rs_stall_on", mc_rsp_stall, 1);
        u1_rsp_stall = 0; u0_rsp_stall = 1;
        #1;
        chk("rs_stall_u0", mc_rsp_stall, 1);
        u0_rsp_stall = 0;
        #1;
        chk("rs_stall_off", mc_rsp_stall, 0);

        // reset mid-stream with five loads queued
        do_reset();
        chk("mr_unexp_clr", rsp_unexp, 0);
        mc_rd_rq_stall = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            u0_req_ld = 1; u0_req_vadr = 48'(i + 16); u0_req_wrd_rdctl = 64'(i);
            tick();
        end
        u0_req_ld = 0;
        chk("mr_queued", arb_idle, 0);
        mc_rd_rq_stall = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        chk("mr_idle", arb_idle, 1);
        chk("mr_ovrflw", q_ovrflw, 0);
        chk("mr_unexp", rsp_unexp, 0);
        chk("mr_stall", u0_rd_rq_stall, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mr_no_req", mc_req_ld, 0);
        end
        chk("mr_idle_end", arb_idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
